// File: rtl/key_debouncer.sv
// key_debouncer
//   Multi-channel push-button conditioner. Each raw key is synchronised,
//   filtered on a shared prescaled sample tick, and turned into a clean level
//   plus one-cycle press/release pulses. An optional auto-repeat re-issues
//   press pulses (flagged by o_rpt) while a key stays held.
//
// Ports
//   i_clk      system clock (everything runs on this clock)
//   i_rst_n    synchronous active-low reset
//   i_key_in   [N_CH] raw asynchronous key inputs
//   o_pressed  [N_CH] debounced level, 1 = held
//   o_press    [N_CH] one-cycle pulse on accepted press or repeat
//   o_release  [N_CH] one-cycle pulse on accepted release
//   o_rpt      [N_CH] one-cycle pulse coincident with a repeat-generated press
//   o_tick     one-cycle sample strobe
module key_debouncer #(
  parameter int N_CH         = 3,
  parameter int DIV          = 65536,
  parameter int STABLE       = 4,
  parameter int ACTIVE_LOW   = 1,
  parameter int REPEAT_EN    = 0,
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [N_CH-1:0] i_key_in,
  output logic [N_CH-1:0] o_pressed,
  output logic [N_CH-1:0] o_press,
  output logic [N_CH-1:0] o_release,
  output logic [N_CH-1:0] o_rpt,
  output logic            o_tick
);

  localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW   = (STABLE > 1) ? $clog2(STABLE) : 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  localparam logic [PW-1:0]   P_LAST   = PW'(DIV - 1);
  localparam logic [CW-1:0]   C_LAST   = CW'(STABLE - 1);
  localparam logic [RW-1:0]   D_LAST   = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0]   R_LAST   = RW'(REPEAT_RATE - 1);
  localparam logic [N_CH-1:0] RAW_IDLE = (ACTIVE_LOW != 0) ? '1 : '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT
  } rpt_state_e;

  logic [PW-1:0]   r_presc;
  logic [N_CH-1:0] r_sync1;
  logic [N_CH-1:0] r_sync2;
  logic [N_CH-1:0] w_s;
  logic            w_tick;

  logic [CW-1:0]   r_cnt       [N_CH];
  logic [CW-1:0]   w_cnt_nxt   [N_CH];
  logic [RW-1:0]   r_rc        [N_CH];
  logic [RW-1:0]   w_rc_nxt    [N_CH];
  rpt_state_e      r_state     [N_CH];
  rpt_state_e      w_state_nxt [N_CH];

  logic [N_CH-1:0] r_pressed;
  logic [N_CH-1:0] w_pressed_nxt;
  logic [N_CH-1:0] r_press;
  logic [N_CH-1:0] w_press_nxt;
  logic [N_CH-1:0] r_release;
  logic [N_CH-1:0] w_release_nxt;
  logic [N_CH-1:0] r_rpt;
  logic [N_CH-1:0] w_rpt_nxt;

  assign w_tick = (r_presc == P_LAST);
  // Normalised sample: 1 means "pressed" regardless of key polarity.
  assign w_s    = (ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;

  always_comb begin
    for (int unsigned ch = 0; ch < N_CH; ch++) begin
      w_cnt_nxt[ch]     = r_cnt[ch];
      w_rc_nxt[ch]      = r_rc[ch];
      w_state_nxt[ch]   = r_state[ch];
      w_pressed_nxt[ch] = r_pressed[ch];
      w_press_nxt[ch]   = 1'b0;
      w_release_nxt[ch] = 1'b0;
      w_rpt_nxt[ch]     = 1'b0;

      if (w_tick) begin
        // Filter: a run of STABLE consecutive differing samples flips the level.
        if (w_s[ch] == r_pressed[ch]) begin
          w_cnt_nxt[ch] = '0;
        end else if (r_cnt[ch] == C_LAST) begin
          w_cnt_nxt[ch]     = '0;
          w_pressed_nxt[ch] = w_s[ch];
          w_press_nxt[ch]   = w_s[ch];
          w_release_nxt[ch] = ~w_s[ch];
        end else begin
          w_cnt_nxt[ch] = r_cnt[ch] + CW'(1);
        end

        // Repeat: a release accepted on this tick overrides any repeat due now.
        if (REPEAT_EN != 0) begin
          if (w_release_nxt[ch]) begin
            w_state_nxt[ch] = ST_IDLE;
            w_rc_nxt[ch]    = '0;
          end else begin
            unique case (r_state[ch])
              ST_IDLE: begin
                if (w_press_nxt[ch]) begin
                  w_state_nxt[ch] = ST_DELAY;
                  w_rc_nxt[ch]    = '0;
                end
              end
              ST_DELAY: begin
                if (r_rc[ch] == D_LAST) begin
                  w_press_nxt[ch] = 1'b1;
                  w_rpt_nxt[ch]   = 1'b1;
                  w_state_nxt[ch] = ST_REPEAT;
                  w_rc_nxt[ch]    = '0;
                end else begin
                  w_rc_nxt[ch] = r_rc[ch] + RW'(1);
                end
              end
              ST_REPEAT: begin
                if (r_rc[ch] == R_LAST) begin
                  w_press_nxt[ch] = 1'b1;
                  w_rpt_nxt[ch]   = 1'b1;
                  w_rc_nxt[ch]    = '0;
                end else begin
                  w_rc_nxt[ch] = r_rc[ch] + RW'(1);
                end
              end
              default: begin
                w_state_nxt[ch] = ST_IDLE;
                w_rc_nxt[ch]    = '0;
              end
            endcase
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_presc   <= '0;
      r_sync1   <= RAW_IDLE;
      r_sync2   <= RAW_IDLE;
      r_pressed <= '0;
      r_press   <= '0;
      r_release <= '0;
      r_rpt     <= '0;
      for (int unsigned ch = 0; ch < N_CH; ch++) begin
        r_cnt[ch]   <= '0;
        r_rc[ch]    <= '0;
        r_state[ch] <= ST_IDLE;
      end
    end else begin
      r_presc   <= w_tick ? '0 : r_presc + PW'(1);
      r_sync1   <= i_key_in;
      r_sync2   <= r_sync1;
      r_pressed <= w_pressed_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
      r_rpt     <= w_rpt_nxt;
      for (int unsigned ch = 0; ch < N_CH; ch++) begin
        r_cnt[ch]   <= w_cnt_nxt[ch];
        r_rc[ch]    <= w_rc_nxt[ch];
        r_state[ch] <= w_state_nxt[ch];
      end
    end
  end

  assign o_pressed = r_pressed;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_rpt     = r_rpt;
  assign o_tick    = w_tick;

endmodule

// File: tb/tb_key_debouncer.sv
// Self-checking bench for key_debouncer (3 channels, active-low keys,
// DIV=4, STABLE=3, auto-repeat with delay 5 / rate 2). A reference model
// predicts every output each cycle from the debounce/repeat rules.
module tb_key_debouncer;

  localparam int N_CH   = 3;
  localparam int DIV    = 4;
  localparam int STABLE = 3;
  localparam int RDELAY = 5;
  localparam int RRATE  = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N_CH-1:0] key_in;
  logic [N_CH-1:0] pressed, press, rel, rpt;
  logic            tick;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  key_debouncer #(
    .N_CH(N_CH), .DIV(DIV), .STABLE(STABLE), .ACTIVE_LOW(1),
    .REPEAT_EN(1), .REPEAT_DELAY(RDELAY), .REPEAT_RATE(RRATE)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_key_in(key_in),
    .o_pressed(pressed), .o_press(press), .o_release(rel),
    .o_rpt(rpt), .o_tick(tick)
  );

  // Reference model state
  int              cyc;            // cycles since reset release
  logic [N_CH-1:0] h1, h2;         // raw key one and two cycles ago
  logic [N_CH-1:0] m_pressed, m_press, m_rel, m_rpt;
  logic            m_tick;
  int              run  [N_CH];    // consecutive differing samples
  int              held [N_CH];    // ticks since accepted press

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Predict the next cycle from current inputs, advance one clock, compare.
  task automatic step();
    logic [N_CH-1:0] s;
    bit              tk;
    if (!rst_n) begin
      cyc = 0;
      h1 = '1; h2 = '1;
      m_pressed = '0; m_press = '0; m_rel = '0; m_rpt = '0;
      for (int ch = 0; ch < N_CH; ch++) begin run[ch] = 0; held[ch] = 0; end
    end else begin
      s  = ~h2;
      tk = (cyc % DIV) == DIV - 1;
      m_press = '0; m_rel = '0; m_rpt = '0;
      if (tk) begin
        for (int ch = 0; ch < N_CH; ch++) begin
          if (s[ch] != m_pressed[ch]) run[ch]++;
          else run[ch] = 0;
          if (run[ch] == STABLE) begin
            run[ch] = 0;
            m_pressed[ch] = s[ch];
            if (s[ch]) begin m_press[ch] = 1'b1; held[ch] = 0; end
            else m_rel[ch] = 1'b1;
          end else if (m_pressed[ch]) begin
            held[ch]++;
            if (held[ch] >= RDELAY && (held[ch] - RDELAY) % RRATE == 0) begin
              m_press[ch] = 1'b1;
              m_rpt[ch]   = 1'b1;
            end
          end
        end
      end
      h2 = h1;
      h1 = key_in;
      cyc++;
    end
    m_tick = (cyc % DIV) == DIV - 1;
    @(posedge clk);
    #1;
    chk("pressed", pressed, m_pressed);
    chk("press",   press,   m_press);
    chk("release", rel,     m_rel);
    chk("rpt",     rpt,     m_rpt);
    chk("tick",    tick,    m_tick);
    chk("press_release_exclusive", press & rel, '0);
  endtask

  initial begin
    bit seen;
    int cnt_rpt;
    rst_n  = 1'b0;
    key_in = '1;
    @(negedge clk);
    repeat (3) step();
    chk("reset_pressed", pressed, 0);
    chk("reset_tick", tick, 0);

    // Key 0 low from cycle 0: ticks at 3,7,11, accepted level in cycle 12.
    rst_n = 1'b1;
    key_in = 3'b110;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (i == 3)  chk("tick_cycle3", tick, 1);
      if (i == 11) chk("no_press_cycle11", press, 0);
    end
    chk("press0_cycle12", press, 3'b001);
    chk("pressed0_cycle12", pressed, 3'b001);
    step();
    chk("press0_one_cycle", press[0], 0);

    // Key 1 chatter: two ticks low then high must not be accepted.
    key_in[1] = 1'b0;
    repeat (8) step();
    key_in[1] = 1'b1;
    repeat (12) step();
    chk("chatter_pressed1", pressed[1], 0);
    key_in[1] = 1'b0;
    repeat (16) step();
    chk("accept_pressed1", pressed[1], 1);

    // Release both keys.
    key_in = '1;
    repeat (20) step();
    chk("released_all", pressed, 0);

    // All three keys pressed in the same cycle, held 40 ticks.
    key_in = '0;
    seen = 1'b0;
    cnt_rpt = 0;
    for (int i = 0; i < 160; i++) begin
      step();
      if (press == 3'b111) seen = 1'b1;
      if (rpt[2]) cnt_rpt++;
    end
    chk("all3_same_cycle", seen, 1);
    chk("repeat_seen", cnt_rpt > 10, 1);

    // Reset mid-press while repeating: outputs clear, no release.
    rst_n = 1'b0;
    step();
    chk("midreset_pressed", pressed, 0);
    chk("midreset_release", rel, 0);
    rst_n = 1'b1;
    repeat (3) step();
    chk("tick_after_reset", tick, 1);
    key_in = '1;
    repeat (20) step();

    // Randomised key activity with occasional long holds and resets.
    for (int seg = 0; seg < 80; seg++) begin
      key_in = N_CH'($urandom);
      if ($urandom_range(0, 29) == 0) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
      repeat ($urandom_range(0, 4) == 0 ? $urandom_range(40, 120) : $urandom_range(1, 24)) step();
    end
    key_in = '1;
    repeat (40) step();
    chk("final_released", pressed, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/key_debouncer.md
# key_debouncer

Parametrised multi-channel push-button conditioner for the board-level demo tops: synchronises N raw key inputs, removes contact chatter by sampling on a shared prescaled tick, and emits clean levels plus single-cycle press/release pulses. An optional auto-repeat mode re-issues press pulses while a key is held, so a top can step through AES state bytes by holding a key. The block feeds the demo control logic, which runs entirely on `clk` and never clocks on key edges.

## Interface
- `N_CH`, 3, number of independent key channels
- `DIV`, 65536, clk cycles per sample tick (>=1; 1 = sample every cycle)
- `STABLE`, 4, consecutive differing samples required to accept a new key state (>=1)
- `ACTIVE_LOW`, 1, 1 = raw key reads 0 when pressed; 0 = reads 1 when pressed
- `REPEAT_EN`, 0, 1 enables auto-repeat
- `REPEAT_DELAY`, 8, ticks from accepted press to first repeat (>=1)
- `REPEAT_RATE`, 2, ticks between subsequent repeats (>=1)

- `clk` in 1 single system clock
- `rst_n` in 1 reset, synchronous, active-low
- `key_in` in N_CH raw asynchronous key inputs
- `pressed` out N_CH debounced level, 1 = held
- `press` out N_CH one-cycle pulse on accepted press or repeat
- `release` out N_CH one-cycle pulse on accepted release
- `rpt` out N_CH one-cycle pulse, coincident with `press`, marking a repeat-generated press
- `tick` out 1 one-cycle sample strobe (debug/test)

## Operation
- Reset (`rst_n`=0 at a clk edge): prescaler=0; synchroniser flops load the unpressed raw level; `pressed`, `press`, `release`, `rpt`, `tick` = 0; all per-channel filter and repeat counters = 0.
- Synchroniser: two flops per channel; output normalised to s=1 when pressed (inverted if ACTIVE_LOW).
- Prescaler: counts 0..DIV-1, wraps to 0; `tick`=1 in the cycle in which it equals DIV-1. Width $clog2(DIV), min 1.
- Filter, per channel, evaluated only on tick: if s == `pressed` then cnt<=0; else if cnt == STABLE-1 then `pressed`<=s, cnt<=0; else cnt<=cnt+1. A run of fewer than STABLE differing samples never changes `pressed`.
- Edge pulses: registered together with `pressed`; on 0->1 `press`=1, on 1->0 `release`=1, each for exactly one cycle.
- Repeat, per channel (REPEAT_EN=1): FSM IDLE -> DELAY on accepted press (rc<=0); in DELAY rc increments per tick, at rc==REPEAT_DELAY-1 on a tick emit `press`+`rpt`, go REPEAT with rc<=0; in REPEAT emit `press`+`rpt` every REPEAT_RATE ticks. Accepted release from any state -> IDLE, rc<=0, no `rpt`. REPEAT_EN=0: FSM held in IDLE, `rpt` constantly 0.
- Channels fully independent; simultaneous presses on several channels pulse in the same cycle.

## Timing
- Raw change to synchronised s: 2 cycles.
- Accepted change: `pressed`/`press`/`release` update the cycle after the STABLE-th consecutive differing tick; worst case 2 + STABLE*DIV + 1 cycles from a clean raw edge.
- Prescaler starts at 0 in the first cycle after reset release; first tick in cycle DIV-1.
- `press` and `release` never both high on one channel in one cycle; a repeat tick coinciding with the accepted release tick produces `release` only.
- Reset asserted mid-press: outputs 0 in the cycle after the reset edge; no `release` pulse is generated for the discarded state.
- Counters never exceed their compare value; no wrap other than prescaler.

## Test plan
- DIV=4, STABLE=3, ACTIVE_LOW=1: drive key_in[0]=0 from cycle 0 after reset -> ticks at cycles 3,7,11; `pressed[0]`=1 and one-cycle `press[0]` at cycle 12; other channels stay 0.
- Same config, key_in[1] low for 2 ticks then high (chatter) -> `pressed[1]` stays 0, no pulses; then low for 3 ticks -> single `press[1]`.
- Release after stable press: key_in[0] high -> after 3 ticks one `release[0]`, `pressed[0]`=0, no `press`.
- REPEAT_EN=1, REPEAT_DELAY=5, REPEAT_RATE=2, key held 40 ticks -> initial `press` (rpt=0), then `press`+`rpt` at tick 5 after acceptance, then every 2 ticks; none after accepted release.
- All three keys pressed in the same cycle -> `press`=3'b111 in one cycle.
- rst_n=0 for one cycle while `pressed[2]`=1 and repeating -> all outputs 0 next cycle, no `release`, prescaler restarts at 0.
